// File: rtl/rst_seq_if.sv
// Lock input and staged-reset outputs of the reset sequencer.
// The sequencer owns the master modport; the consumer of the resets uses the slave modport.
interface rst_seq_if #(
  parameter int unsigned CNT_W = 8
);
  logic             pll_locked;
  logic             rst_core_n;
  logic             rst_periph_n;
  logic             ready;
  logic             lock_lost;
  logic [CNT_W-1:0] lock_loss_count;

  modport master (
    input  pll_locked,
    output rst_core_n,
    output rst_periph_n,
    output ready,
    output lock_lost,
    output lock_loss_count
  );

  modport slave (
    output pll_locked,
    input  rst_core_n,
    input  rst_periph_n,
    input  ready,
    input  lock_lost,
    input  lock_loss_count
  );
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: debounces PLL lock, then releases core and peripheral resets in stages.
// Define RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise it reads 0.
module rst_seq #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_DELAY        = 16,
  parameter int unsigned CNT_W              = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  rst_seq_if.master bus
);

  localparam int unsigned CntMax = (LOCK_STABLE_CYCLES > STAGE_DELAY) ?
                                   LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] LockLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(STAGE_DELAY - 1);

  typedef enum logic [1:0] {StReset, StWaitLock, StCore, StRun} state_e;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_s;
  logic                   lock_s;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            loss;

  logic core_q, core_d;
  logic periph_q, periph_d;
  logic lost_q, lost_d;

  // Both chains share the async reset so rst_n assertion clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign rst_s  = rst_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StReset;
      cnt_q    <= '0;
      core_q   <= 1'b0;
      periph_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      core_q   <= core_d;
      periph_q <= periph_d;
      lost_q   <= lost_d;
    end
  end

  // One counter serves both the lock debounce and the stage delay; it clears on every hand-off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss    = 1'b0;
    unique case (state_q)
      StReset: begin
        if (rst_s) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StCore;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCore: begin
        if (!lock_s) begin
          loss    = 1'b1;
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == DelayLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          loss    = 1'b1;
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StReset;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    core_d   = (state_d == StCore) || (state_d == StRun);
    periph_d = (state_d == StRun);
    lost_d   = lost_q | loss;
  end

  assign bus.rst_core_n   = core_q;
  assign bus.rst_periph_n = periph_q;
  assign bus.ready        = periph_q;
  assign bus.lock_lost    = lost_q;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (loss && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign bus.lock_loss_count = count_q;
`else
  assign bus.lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed scenarios plus randomized lock patterns
// compared each cycle against an event-level model of the sequencing rules.
module tb_rst_seq;
  localparam int unsigned SS  = 2;
  localparam int unsigned LSC = 8;
  localparam int unsigned SD  = 4;
  localparam int unsigned CW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rst_seq_if #(.CNT_W(CW)) bus ();

  rst_seq #(
    .SYNC_STAGES       (SS),
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_DELAY       (SD),
    .CNT_W             (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: pll sample pipeline, lock run length, release flag, cycles since release.
  bit m_s0, m_ls, m_rel, m_lost;
  int m_wait, m_run, m_since, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s0 = 0; m_ls = 0; m_rel = 0; m_lost = 0;
    m_wait = SS + 1; m_run = 0; m_since = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit p);
    bit ls;
    ls   = m_ls;
    m_ls = m_s0;
    m_s0 = p;
    if (m_wait > 0) begin
      m_wait--;
    end else if (!m_rel) begin
      m_run = ls ? m_run + 1 : 0;
      if (m_run == LSC) begin
        m_rel   = 1;
        m_since = 0;
      end
    end else if (!ls) begin
      m_rel  = 0;
      m_run  = 0;
      m_lost = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      m_since++;
    end
  endtask

  function automatic int exp_count();
`ifdef RST_SEQ_LOSS_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag);
    bit periph;
    periph = m_rel && (m_since >= SD);
    check({tag, ".core"},   32'(bus.rst_core_n),      32'(m_rel));
    check({tag, ".periph"}, 32'(bus.rst_periph_n),    32'(periph));
    check({tag, ".ready"},  32'(bus.ready),           32'(periph));
    check({tag, ".lost"},   32'(bus.lock_lost),       32'(m_lost));
    check({tag, ".count"},  32'(bus.lock_loss_count), 32'(exp_count()));
  endtask

  task automatic step(input bit p, input string tag);
    bus.pll_locked = p;
    @(posedge clk);
    model_edge(p);
    #1;
    check_all(tag);
  endtask

  // Hard reset then hold lock low until the FSM is waiting for lock.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < SS + 1; i++) step(1'b0, "rst_rel");
  endtask

  task automatic wait_core(input string tag, output int e);
    e = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, tag);
      if (bus.rst_core_n === 1'b1) begin
        e = i;
        break;
      end
    end
  endtask

  int   e_core, e_periph, e_fall;
  logic periph_seen;
  int   len;
  bit   lvl;

  initial begin
    bus.pll_locked = 1'b0;
    model_reset();
    #2;
    check_all("por");

    // Clean power-up
    do_reset();
    e_core = 0; e_periph = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, "pwrup");
      if (e_core == 0 && bus.rst_core_n === 1'b1) e_core = i;
      if (e_periph == 0 && bus.rst_periph_n === 1'b1) e_periph = i;
    end
    check("pwrup.core_edge", 32'(e_core), 32'd10);
    check("pwrup.periph_edge", 32'(e_periph), 32'd14);

    // Glitch during debounce restarts the count from the re-rise
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, "glitch");
    step(1'b0, "glitch");
    wait_core("glitch", e_core);
    check("glitch.core_edge", 32'(e_core), 32'd10);
    check("glitch.count", 32'(bus.lock_loss_count), 32'd0);
    for (int i = 0; i < SD; i++) step(1'b1, "glitch_run");
    check("glitch.ready", 32'(bus.ready), 32'd1);

    // Lock loss in RUN
    e_fall = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, "loss");
      if (e_fall == 0 && bus.rst_core_n === 1'b0) e_fall = i;
    end
    check("loss.fall_edge", 32'(e_fall), 32'd3);
    check("loss.lost", 32'(bus.lock_lost), 32'd1);
    wait_core("relock", e_core);
    check("relock.core_edge", 32'(e_core), 32'd10);
    for (int i = 0; i < SD; i++) step(1'b1, "relock_run");
    check("relock.ready", 32'(bus.ready), 32'd1);

    // Saturation over five losses from RUN
    do_reset();
    for (int n = 0; n < 5; n++) begin
      wait_core("sat", e_core);
      for (int i = 0; i < SD; i++) step(1'b1, "sat_run");
      for (int i = 0; i < SS + 1; i++) step(1'b0, "sat_loss");
    end
`ifdef RST_SEQ_LOSS_CNT_EN
    check("sat.count", 32'(bus.lock_loss_count), 32'd3);
`else
    check("sat.count", 32'(bus.lock_loss_count), 32'd0);
`endif
    check("sat.lost", 32'(bus.lock_lost), 32'd1);

    // Asynchronous reset pulse during CORE
    wait_core("core_rst", e_core);
    step(1'b1, "core_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async.core", 32'(bus.rst_core_n), 32'd0);
    check("async.lost", 32'(bus.lock_lost), 32'd0);
    check("async.count", 32'(bus.lock_loss_count), 32'd0);
    model_reset();
    bus.pll_locked = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < SS + 1; i++) step(1'b0, "async_rel");
    wait_core("async_relock", e_core);
    check("async.core_edge", 32'(e_core), 32'd10);

    // Lock loss coinciding with the CORE->RUN edge
    step(1'b1, "c2r");
    periph_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, "c2r");
      if (bus.rst_periph_n !== 1'b0) periph_seen = 1'b1;
    end
    check("c2r.periph_never", 32'(periph_seen), 32'd0);
    check("c2r.core", 32'(bus.rst_core_n), 32'd0);
    check("c2r.lost", 32'(bus.lock_lost), 32'd1);

    // Randomized lock patterns
    do_reset();
    for (int n = 0; n < 60; n++) begin
      lvl = ($urandom_range(0, 3) != 0);
      len = lvl ? $urandom_range(1, 20) : $urandom_range(1, 4);
      for (int i = 0; i < len; i++) step(lvl, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
